// File: rtl/serial_add44_pkg.sv
// Shared types and sizing constants for the bit-serial adder/subtractor.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH + 1);

   // Counter width for an arbitrary operand width.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_add44_fa1.sv
// One-bit full adder used as the serial datapath of serial_add44.
module fa1 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add44.sv
// Bit-serial unsigned adder, LSB first, one bit per RUN cycle.
// Optional macro SERIAL_ADD_SUB_EN adds the MODE port and A-B subtraction.
module serial_add44
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             MODE,
`endif
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH:0]   S
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             mode_q;
   logic             mode_in;
   logic             fa_s;
   logic             fa_co;
   logic             last;

`ifdef SERIAL_ADD_SUB_EN
   assign mode_in = MODE;
`else
   assign mode_in = 1'b0;
`endif

   assign last = (cnt == CW'(WIDTH - 1));

   // Subtraction is A + ~B + 1: B is inverted here, the +1 comes from the carry preload.
   fa1 u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0] ^ mode_q),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      case (state_q)
         IDLE: if (START) state_d = RUN;
         RUN: begin
            BUSY = 1'b1;
            if (last) state_d = FIN;
         end
         FIN: begin
            DONE    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         mode_q <= 1'b0;
         S      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (START) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  cnt    <= '0;
                  carry  <= mode_in;
                  mode_q <= mode_in;
               end
            end
            RUN: begin
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_co;
               cnt    <= cnt + CW'(1);
               // S is published only once all bits exist, so it never shows a partial sum.
               if (last) begin
                  S <= {(mode_q ? ~fa_co : fa_co), fa_s, sum_sh[WIDTH-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_add44.md
SERIAL_ADD44 -- requirements
Module: serial_add44

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: CLK  input  1  rising-edge clock; all state updates on the rising edge of CLK.
REQ-003 Port: RST  input  1  reset; synchronous and active-high.
REQ-004 Port: START  input  1  request; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  first operand; captured when START is accepted.
REQ-006 Port: B  input  WIDTH  second operand; captured when START is accepted.
REQ-007 Port: MODE  input  1  0 = add, 1 = subtract (A-B); port exists only with SERIAL_ADD_SUB_EN.
REQ-008 Port: BUSY  output  1  high while bits are being computed.
REQ-009 Port: DONE  output  1  one-cycle pulse; result is valid.
REQ-010 Port: S  output  WIDTH+1  result; S[WIDTH] is carry-out (add) or borrow (subtract).

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and FIN.
- IDLE -> RUN on START=1.
- RUN -> FIN after exactly WIDTH RUN cycles.
- FIN -> IDLE unconditionally.
REQ-012 On START accepted, the block SHALL:
- load A and B into shift registers;
- clear the bit counter;
- set carry to 0 (add) or 1 (subtract);
- latch MODE for the whole operation.
REQ-013 Each RUN cycle SHALL:
- compute one sum bit from the LSBs of the A register, the B register (inverted when subtracting) and carry;
- shift that bit into the result register from the MSB side;
- shift the A and B registers right by one;
- update carry.
REQ-014 On the last RUN cycle, S SHALL be updated:
- S[WIDTH-1:0] = the WIDTH computed bits;
- S[WIDTH] = final carry (add) or inverted final carry (subtract), giving 1 exactly when A<B unsigned.
REQ-015 Latency: START sampled at edge k -> BUSY high after edges k..k+WIDTH-1 -> DONE high for the one cycle after edge k+WIDTH.
REQ-016 BUSY SHALL be high only in RUN; DONE SHALL be high only in FIN.
REQ-017 S SHALL hold its value from FIN until the next operation's final RUN edge; S SHALL NOT show partial results.
REQ-018 START in RUN or FIN SHALL be ignored and not queued.
REQ-019 START may be held high continuously; a new operation SHALL then begin on the first IDLE cycle after FIN, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-020 A, B and MODE changes after acceptance SHALL NOT affect the running operation.
REQ-021 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1) on the S bus, with no overflow flag.

Reset
REQ-022 RST=1 at a rising edge SHALL force IDLE, BUSY=0, DONE=0, S=0, carry=0, counter=0 and shift registers=0.
REQ-023 RST asserted mid-RUN or in FIN SHALL abort the operation: no DONE pulse, S=0.
REQ-024 RST SHALL have priority over START on the same edge.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN, when defined, SHALL add the MODE port and the subtract behaviour of REQ-012 and REQ-014.
REQ-026 Without SERIAL_ADD_SUB_EN, the MODE port SHALL be absent, the block SHALL add only, and carry SHALL always load as 0.

Structure
REQ-027 Package serial_add_pkg SHALL hold:
- the state enum type (IDLE, RUN, FIN);
- the default WIDTH constant;
- the counter width constant $clog2(WIDTH+1).
REQ-028 A 1-bit full-adder sub-module, fa1 (inputs a, b, ci; outputs s, co), SHALL be instantiated once for the serial datapath.

Verification
REQ-029 Reset: RST high for 2 cycles during RUN with A=0011, B=0101 -> IDLE, BUSY=0, DONE=0, S=00000, and no DONE pulse afterward.
REQ-030 Add: A=0011, B=0101, START one cycle -> BUSY for 4 cycles, then DONE for 1 cycle with S=01000.
REQ-031 Carry boundary: A=1111, B=1111 -> S=11110; A=1111, B=0001 -> S=10000; A=0000, B=0000 -> S=00000.
REQ-032 Busy-ignore: START re-pulsed with A=0001, B=0001 during RUN of A=0111, B=0011 -> single DONE with S=01010; no second DONE.
REQ-033 Back-to-back: START held high with A=0001, B=0001 -> DONE every 6 cycles, S=00010 each time.
REQ-034 SERIAL_ADD_SUB_EN, MODE=1:
- A=0111, B=0011 -> S=00100;
- A=0011, B=0101 -> S=11110 (borrow set);
- A=1111, B=1111 -> S=00000.
